id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter ADR_W, default 5, register-address width.
REQ-003 SHALL have port clk input 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst input 1; reset is synchronous and active-low.
REQ-005 SHALL have port id_valid input 1, IF/ID holds a real instruction.
REQ-006 SHALL have ports id_rs, id_rt, id_rd input ADR_W each, decoded register addresses.
REQ-007 SHALL have port id_usesRt input 1, instruction reads rt as a source.
REQ-008 SHALL have port id_imm input DATA_W, sign-extended immediate.
REQ-009 SHALL have port id_ctrl input ctrl_t: regWrite, memRead, memWrite, memToReg, aluSrc, regDst, aluOp[2:0].
REQ-010 SHALL have ports readData1, readData2 input DATA_W, register-file outputs for id_rs/id_rt.
REQ-011 SHALL have ports wb_regWrite input 1, wb_writeAdr input ADR_W, and wb_writeData input DATA_W: the writeback port in flight this cycle.
REQ-012 SHALL have port ex_flush input 1, EX-stage branch/jump redirect.
REQ-013 SHALL have port stall_ifid output 1, freeze PC and IF/ID this cycle.
REQ-014 SHALL have ports ex_valid output 1, ex_ctrl output ctrl_t, ex_rs and ex_rt output ADR_W, ex_dst output ADR_W, ex_a/ex_b/ex_imm output DATA_W.
REQ-015 SHALL have port bubble_cnt output 16, count of inserted bubbles.

Function
REQ-016 Operand A SHALL be 0 if id_rs==0; else wb_writeData if wb_regWrite && wb_writeAdr==id_rs; else readData1. Operand B is identical using id_rt/readData2.
REQ-017 ex_dst SHALL latch id_rd when id_ctrl.regDst=1, else id_rt.
REQ-018 Load-use hazard SHALL be ex_valid && ex_ctrl.memRead && ex_dst!=0 && id_valid && (ex_dst==id_rs || (id_usesRt && ex_dst==id_rt)).
REQ-019 stall_ifid SHALL equal the hazard AND NOT ex_flush; it is combinational, same-cycle.
REQ-020 Priority per posedge SHALL be: reset > ex_flush > hazard > normal.
REQ-021 On ex_flush or hazard, the next state SHALL be a bubble: ex_valid=0, ex_ctrl all zero; data registers may hold any value.
REQ-022 Normal: all ex_* SHALL latch ID values with one-cycle latency; ex_valid<=id_valid; ex_ctrl zeroed when id_valid=0.
REQ-023 A hazard SHALL stall exactly one cycle: the bubble clears the hazard the next cycle, and the re-presented instruction then latches with WB bypass applied.
REQ-024 bubble_cnt SHALL increment by 1 on each hazard bubble (not flush bubbles) and saturate at 16'hFFFF.
REQ-025 wb_writeAdr==0 SHALL never forward; ex_dst==0 SHALL never stall.

Reset
REQ-026 With rst=0 at posedge: ex_valid=0, ex_ctrl=0, ex_rs/ex_rt/ex_dst=0, ex_a/ex_b/ex_imm=0, bubble_cnt=0.
REQ-027 stall_ifid SHALL read 0 while ex_valid=0, including during reset and the first cycle after.
REQ-028 Reset asserted mid-stall SHALL discard the stalled instruction with no residual stall.

Structure
REQ-029 ctrl_t typedef, aluOp encodings, DATA_W/ADR_W defaults SHALL live in shared package mips_pkg.
REQ-030 Hazard compare and stall generation SHALL be one sub-module hazard_detect; operand bypass stays inline.

Verification
REQ-031 lw $8 in EX (memRead, dst=8), ID add $9,$8,$3 -> stall_ifid=1 one cycle, bubble, bubble_cnt=1, add then latches.
REQ-032 ID rs=5, readData1=7, wb_regWrite=1, wb_writeAdr=5, wb_writeData=99 -> ex_a=99 next cycle.
REQ-033 ID rs=0, readData1=0x1234, wb writes $0 with 55 -> ex_a=0.
REQ-034 Hazard and ex_flush same cycle -> stall_ifid=0, ex_valid=0, bubble_cnt unchanged.
REQ-035 Preload bubble_cnt=16'hFFFF via 65535 hazards -> next hazard leaves 16'hFFFF.
REQ-036 rst=0 during stall cycle -> all outputs 0 next edge, stall_ifid=0 after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS pipeline slice: control bundle,
// ALU op encodings and datapath widths.
package mips_pkg;

    localparam int DATA_W_DFLT = 32;
    localparam int ADR_W_DFLT  = 5;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;
    localparam logic [2:0] ALU_FUNCT = 3'd7;

    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       aluSrc;
        logic       regDst;
        logic [2:0] aluOp;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Counter bump that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] bump_sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector between the instruction in EX and the one in ID.
// Stall is suppressed by an EX redirect and while reset is held.
module hazard_detect
    import mips_pkg::*;
#(
    parameter int ADR_W = ADR_W_DFLT
) (
    input  logic             i_rst,
    input  logic             i_ex_valid,
    input  logic             i_ex_mem_read,
    input  logic [ADR_W-1:0] i_ex_dst,
    input  logic             i_id_valid,
    input  logic [ADR_W-1:0] i_id_rs,
    input  logic [ADR_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_ex_flush,
    output logic             o_hazard,
    output logic             o_stall
);

    logic w_ex_is_load;
    logic w_rs_match;
    logic w_rt_match;

    // $0 never carries a real result, so a load targeting it cannot stall.
    assign w_ex_is_load = i_ex_valid && i_ex_mem_read && (i_ex_dst != '0);
    assign w_rs_match   = (i_ex_dst == i_id_rs);
    assign w_rt_match   = i_id_uses_rt && (i_ex_dst == i_id_rt);

    assign o_hazard = w_ex_is_load && i_id_valid && (w_rs_match || w_rt_match);
    assign o_stall  = o_hazard && !i_ex_flush && i_rst;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID operand bypass and load-use stall.
// Inserts a bubble on EX redirect or load-use; counts load-use bubbles.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADR_W  = ADR_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADR_W-1:0]  id_rs,
    input  logic [ADR_W-1:0]  id_rt,
    input  logic [ADR_W-1:0]  id_rd,
    input  logic              id_usesRt,
    input  logic [DATA_W-1:0] id_imm,
    input  ctrl_t             id_ctrl,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    input  logic              wb_regWrite,
    input  logic [ADR_W-1:0]  wb_writeAdr,
    input  logic [DATA_W-1:0] wb_writeData,
    input  logic              ex_flush,
    output logic              stall_ifid,
    output logic              ex_valid,
    output ctrl_t             ex_ctrl,
    output logic [ADR_W-1:0]  ex_rs,
    output logic [ADR_W-1:0]  ex_rt,
    output logic [ADR_W-1:0]  ex_dst,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [15:0]       bubble_cnt
);

    logic              r_ex_valid;
    ctrl_t             r_ex_ctrl;
    logic [ADR_W-1:0]  r_ex_rs;
    logic [ADR_W-1:0]  r_ex_rt;
    logic [ADR_W-1:0]  r_ex_dst;
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;
    logic [DATA_W-1:0] r_ex_imm;
    logic [15:0]       r_bubble_cnt;

    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [ADR_W-1:0]  w_dst;
    logic              w_hazard;
    logic              w_stall;

    // Register-file read is one write behind; the value being written back
    // this cycle wins. $0 reads as zero, which also blocks forwarding of it.
    always_comb begin
        w_op_a = readData1;
        if (id_rs == '0) begin
            w_op_a = '0;
        end else if (wb_regWrite && (wb_writeAdr == id_rs)) begin
            w_op_a = wb_writeData;
        end
    end

    always_comb begin
        w_op_b = readData2;
        if (id_rt == '0) begin
            w_op_b = '0;
        end else if (wb_regWrite && (wb_writeAdr == id_rt)) begin
            w_op_b = wb_writeData;
        end
    end

    assign w_dst = id_ctrl.regDst ? id_rd : id_rt;

    hazard_detect #(
        .ADR_W (ADR_W)
    ) u_hazard_detect (
        .i_rst         (rst),
        .i_ex_valid    (r_ex_valid),
        .i_ex_mem_read (r_ex_ctrl.memRead),
        .i_ex_dst      (r_ex_dst),
        .i_id_valid    (id_valid),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_uses_rt  (id_usesRt),
        .i_ex_flush    (ex_flush),
        .o_hazard      (w_hazard),
        .o_stall       (w_stall)
    );

    // Bubbles only clear valid/ctrl; the data registers keep stale values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= CTRL_NOP;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_dst     <= '0;
            r_ex_a       <= '0;
            r_ex_b       <= '0;
            r_ex_imm     <= '0;
            r_bubble_cnt <= '0;
        end else if (ex_flush) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= CTRL_NOP;
        end else if (w_hazard) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= CTRL_NOP;
            r_bubble_cnt <= bump_sat16(r_bubble_cnt);
        end else begin
            r_ex_valid <= id_valid;
            r_ex_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
            r_ex_rs    <= id_rs;
            r_ex_rt    <= id_rt;
            r_ex_dst   <= w_dst;
            r_ex_a     <= w_op_a;
            r_ex_b     <= w_op_b;
            r_ex_imm   <= id_imm;
        end
    end

    assign stall_ifid = w_stall;
    assign ex_valid   = r_ex_valid;
    assign ex_ctrl    = r_ex_ctrl;
    assign ex_rs      = r_ex_rs;
    assign ex_rt      = r_ex_rt;
    assign ex_dst     = r_ex_dst;
    assign ex_a       = r_ex_a;
    assign ex_b       = r_ex_b;
    assign ex_imm     = r_ex_imm;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed pipeline scenarios, a behavioural model of
// the stage checked every cycle, plus literal expectations at key points.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        id_usesRt = 1'b0;
    logic [31:0] id_imm = '0;
    ctrl_t       id_ctrl = '0;
    logic [31:0] readData1 = '0, readData2 = '0;
    logic        wb_regWrite = 1'b0;
    logic [4:0]  wb_writeAdr = '0;
    logic [31:0] wb_writeData = '0;
    logic        ex_flush = 1'b0;
    logic        stall_ifid;
    logic        ex_valid;
    ctrl_t       ex_ctrl;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [15:0] bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;
    logic ovr_req = 1'b0;
    logic [15:0] ovr_val = '0;

    // Model of the architectural EX-stage contents.
    logic        m_valid = 1'b0;
    ctrl_t       m_ctrl = '0;
    logic [4:0]  m_rs = '0, m_rt = '0, m_dst = '0;
    logic [31:0] m_a = '0, m_b = '0, m_imm = '0;
    logic [15:0] m_cnt = '0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_usesRt(id_usesRt), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .readData1(readData1), .readData2(readData2), .wb_regWrite(wb_regWrite),
        .wb_writeAdr(wb_writeAdr), .wb_writeData(wb_writeData), .ex_flush(ex_flush),
        .stall_ifid(stall_ifid), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ctrl_t mk_ctrl(input logic rw, mr, mw, m2r, src, dst, input logic [2:0] op);
        ctrl_t c;
        c.regWrite = rw; c.memRead = mr; c.memWrite = mw; c.memToReg = m2r;
        c.aluSrc = src; c.regDst = dst; c.aluOp = op;
        return c;
    endfunction

    // ID needs a register the load in EX has not produced yet.
    function automatic logic model_hazard();
        logic needs_rs, needs_rt;
        needs_rs = (m_dst == id_rs);
        needs_rt = id_usesRt && (m_dst == id_rt);
        return m_valid && m_ctrl.memRead && (m_dst != 5'd0) && id_valid && (needs_rs || needs_rt);
    endfunction

    // Newest architectural value of register r this cycle.
    function automatic logic [31:0] latest(input logic [4:0] r, input logic [31:0] rf_val);
        if (r == 5'd0) return 32'd0;
        if (wb_regWrite && wb_writeAdr == r) return wb_writeData;
        return rf_val;
    endfunction

    always @(posedge clk) begin
        logic hz;
        hz = model_hazard();
        if (ovr_req) m_cnt = ovr_val;
        if (!rst) begin
            m_valid = 1'b0; m_ctrl = '0; m_rs = '0; m_rt = '0; m_dst = '0;
            m_a = '0; m_b = '0; m_imm = '0; m_cnt = '0;
        end else if (ex_flush || hz) begin
            m_valid = 1'b0;
            m_ctrl  = '0;
            if (!ex_flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_valid = id_valid;
            m_ctrl  = id_valid ? id_ctrl : ctrl_t'('0);
            m_rs    = id_rs;
            m_rt    = id_rt;
            m_dst   = id_ctrl.regDst ? id_rd : id_rt;
            m_a     = latest(id_rs, readData1);
            m_b     = latest(id_rt, readData2);
            m_imm   = id_imm;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp stall", 64'(stall_ifid), 64'(rst && model_hazard() && !ex_flush));
            check("cmp valid", 64'(ex_valid), 64'(m_valid));
            check("cmp ctrl", 64'(ex_ctrl), 64'(m_ctrl));
            check("cmp bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
            if (m_valid) begin
                check("cmp rs", 64'(ex_rs), 64'(m_rs));
                check("cmp rt", 64'(ex_rt), 64'(m_rt));
                check("cmp dst", 64'(ex_dst), 64'(m_dst));
                check("cmp a", 64'(ex_a), 64'(m_a));
                check("cmp b", 64'(ex_b), 64'(m_b));
                check("cmp imm", 64'(ex_imm), 64'(m_imm));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, rt, rd, input logic urt,
                          input ctrl_t c, input logic [31:0] d1, d2, imm);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_usesRt = urt;
        id_ctrl = c; readData1 = d1; readData2 = d2; id_imm = imm;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] adr, input logic [31:0] d);
        wb_regWrite = we; wb_writeAdr = adr; wb_writeData = d;
    endtask

    ctrl_t c_lw, c_add;

    initial begin
        c_lw  = mk_ctrl(1, 1, 0, 1, 1, 0, ALU_ADD);
        c_add = mk_ctrl(1, 0, 0, 0, 0, 1, ALU_FUNCT);

        // Reset state and first cycle after release
        cyc();
        cyc();
        chk_en = 1'b1;
        check("reset valid", 64'(ex_valid), 64'd0);
        check("reset ctrl", 64'(ex_ctrl), 64'd0);
        check("reset a", 64'(ex_a), 64'd0);
        check("reset dst", 64'(ex_dst), 64'd0);
        check("reset bubble_cnt", 64'(bubble_cnt), 64'd0);
        check("reset stall", 64'(stall_ifid), 64'd0);
        rst = 1'b1;
        #1 check("post-reset stall", 64'(stall_ifid), 64'd0);

        // lw $8,0($29) then add $9,$8,$3: one bubble, then add with bypassed $8
        set_id(1, 5'd29, 5'd8, 5'd0, 0, c_lw, 32'h1000, 32'h0, 32'h0);
        cyc();
        check("lw latched", 64'(ex_valid), 64'd1);
        set_id(1, 5'd8, 5'd3, 5'd9, 1, c_add, 32'd111, 32'd30, 32'h0);
        #1 check("load-use stall", 64'(stall_ifid), 64'd1);
        cyc();
        check("load-use bubble valid", 64'(ex_valid), 64'd0);
        check("load-use bubble ctrl", 64'(ex_ctrl), 64'd0);
        check("load-use bubble_cnt", 64'(bubble_cnt), 64'd1);
        set_wb(1, 5'd8, 32'h0000DEAD);
        #1 check("stall cleared", 64'(stall_ifid), 64'd0);
        cyc();
        check("add valid", 64'(ex_valid), 64'd1);
        check("add dst", 64'(ex_dst), 64'd9);
        check("add a bypass", 64'(ex_a), 64'h0000DEAD);
        check("add b", 64'(ex_b), 64'd30);
        check("add ctrl", 64'(ex_ctrl), 64'(c_add));

        // WB bypass to rs
        set_id(1, 5'd5, 5'd6, 5'd10, 1, c_add, 32'd7, 32'd8, 32'h0);
        set_wb(1, 5'd5, 32'd99);
        cyc();
        check("bypass rs a", 64'(ex_a), 64'd99);
        check("bypass rs b", 64'(ex_b), 64'd8);

        // $0 reads zero even when WB targets $0
        set_id(1, 5'd0, 5'd0, 5'd11, 1, c_add, 32'h1234, 32'h77, 32'h0);
        set_wb(1, 5'd0, 32'd55);
        cyc();
        check("zero reg a", 64'(ex_a), 64'd0);
        check("zero reg b", 64'(ex_b), 64'd0);

        // WB to $0 does not forward into a nonzero source; rt bypass and imm
        set_id(1, 5'd4, 5'd12, 5'd13, 1, c_add, 32'h44, 32'h5, 32'hFFFF_FFF0);
        set_wb(1, 5'd0, 32'd55);
        cyc();
        check("wb0 no forward", 64'(ex_a), 64'h44);
        set_id(1, 5'd4, 5'd12, 5'd13, 1, c_add, 32'h44, 32'h5, 32'hFFFF_FFF0);
        set_wb(1, 5'd12, 32'hABC);
        cyc();
        check("bypass rt b", 64'(ex_b), 64'hABC);
        check("imm pass", 64'(ex_imm), 64'hFFFF_FFF0);
        set_wb(0, 5'd0, 32'd0);

        // Invalid ID instruction latches as a bubble with zeroed ctrl
        set_id(0, 5'd1, 5'd2, 5'd3, 1, c_add, 32'h1, 32'h2, 32'h0);
        cyc();
        check("invalid id valid", 64'(ex_valid), 64'd0);
        check("invalid id ctrl", 64'(ex_ctrl), 64'd0);

        // Load targeting $0 never stalls
        set_id(1, 5'd29, 5'd0, 5'd0, 0, c_lw, 32'h1000, 32'h0, 32'h0);
        cyc();
        set_id(1, 5'd0, 5'd0, 5'd14, 1, c_add, 32'h0, 32'h0, 32'h0);
        #1 check("dst0 no stall", 64'(stall_ifid), 64'd0);
        set_id(1, 5'd29, 5'd8, 5'd0, 0, c_lw, 32'h1000, 32'h0, 32'h0);
        cyc();

        // lw $8 in EX: rt-only match needs usesRt, invalid ID never stalls
        set_id(1, 5'd3, 5'd8, 5'd15, 0, c_lw, 32'h0, 32'h0, 32'h4);
        #1 check("rt unused no stall", 64'(stall_ifid), 64'd0);
        set_id(0, 5'd8, 5'd8, 5'd15, 1, c_add, 32'h0, 32'h0, 32'h0);
        #1 check("id invalid no stall", 64'(stall_ifid), 64'd0);
        set_id(1, 5'd3, 5'd8, 5'd15, 1, c_add, 32'h0, 32'h0, 32'h0);
        #1 check("rt hazard stall", 64'(stall_ifid), 64'd1);
        cyc();
        check("rt hazard bubble_cnt", 64'(bubble_cnt), 64'd2);

        // Hazard coinciding with EX redirect: flush wins, no count
        set_id(1, 5'd29, 5'd8, 5'd0, 0, c_lw, 32'h1000, 32'h0, 32'h0);
        cyc();
        set_id(1, 5'd8, 5'd3, 5'd9, 1, c_add, 32'h0, 32'h0, 32'h0);
        ex_flush = 1'b1;
        #1 check("flush masks stall", 64'(stall_ifid), 64'd0);
        cyc();
        ex_flush = 1'b0;
        check("flush bubble valid", 64'(ex_valid), 64'd0);
        check("flush bubble_cnt", 64'(bubble_cnt), 64'd2);

        // Reset during a stall cycle drops the stalled instruction
        set_id(1, 5'd29, 5'd8, 5'd0, 0, c_lw, 32'h1000, 32'h0, 32'h0);
        cyc();
        set_id(1, 5'd8, 5'd3, 5'd9, 1, c_add, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        #1 check("stall during reset", 64'(stall_ifid), 64'd0);
        cyc();
        check("mid-stall reset valid", 64'(ex_valid), 64'd0);
        check("mid-stall reset dst", 64'(ex_dst), 64'd0);
        check("mid-stall reset a", 64'(ex_a), 64'd0);
        check("mid-stall reset bubble_cnt", 64'(bubble_cnt), 64'd0);
        rst = 1'b1;
        #1 check("stall after release", 64'(stall_ifid), 64'd0);
        cyc();
        check("add after reset valid", 64'(ex_valid), 64'd1);

        // Saturation: preload one below the ceiling, then two more hazards
        chk_en = 1'b0;
        set_id(0, 5'd0, 5'd0, 5'd0, 0, ctrl_t'('0), 32'h0, 32'h0, 32'h0);
        force dut.r_bubble_cnt = 16'hFFFE;
        ovr_val = 16'hFFFE;
        ovr_req = 1'b1;
        #1 release dut.r_bubble_cnt;
        cyc();
        ovr_req = 1'b0;
        chk_en  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_id(1, 5'd29, 5'd8, 5'd0, 0, c_lw, 32'h1000, 32'h0, 32'h0);
            cyc();
            set_id(1, 5'd8, 5'd3, 5'd9, 1, c_add, 32'h0, 32'h0, 32'h0);
            cyc();
            check("saturated bubble_cnt", 64'(bubble_cnt), 64'hFFFF);
        end

        cyc();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
